// File: rtl/dst_addr_pipe.sv
// dst_addr_pipe: picks the write-register address of the D-stage instruction
// from NUM_IN candidates. It then carries that address with its Tnew down a
// DEPTH-stage pipeline (E/M/W).
// It also compares a source-register query against every in-flight stage.
// The results are forwarding-hit and stall-request signals for the hazard unit.
// Optional feature macro: DST_HAZARD_DETECT_EN.
// When it is defined, the comparators drive fwd_hit and stall_req.
// When it is undefined, both outputs are tied to 0 and the query inputs are ignored.
module dst_addr_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 3,
    parameter int TW     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_addr,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    wr_en,
    input  logic [TW-1:0]           tnew_in,
    input  logic                    stall,
    input  logic                    flush,
    output logic [DEPTH*WIDTH-1:0]  stage_addr,
    output logic [DEPTH*TW-1:0]     stage_tnew,
    input  logic [WIDTH-1:0]        qry_addr,
    input  logic [TW-1:0]           qry_tuse,
    output logic [DEPTH-1:0]        fwd_hit,
    output logic                    stall_req
);

    logic [WIDTH-1:0] addr_q [DEPTH];
    logic [WIDTH-1:0] addr_d [DEPTH];
    logic [TW-1:0]    tnew_q [DEPTH];
    logic [TW-1:0]    tnew_d [DEPTH];
    logic [WIDTH-1:0] mux_addr;

    // Tnew counts down by one per stage and stops at 0.
    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Candidate select. An out-of-range sel or a non-writing instruction yields address 0, which means "no write".
    always_comb begin
        mux_addr = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (wr_en && (sel == SEL_W'(i))) begin
                mux_addr = in_addr[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state rules per stage. Flush beats stall at stage 0; either one bubbles stage 1; later stages always advance.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            addr_d[k] = addr_q[k];
            tnew_d[k] = tnew_q[k];
        end

        if (flush) begin
            addr_d[0] = '0;
            tnew_d[0] = '0;
        end else if (!stall) begin
            addr_d[0] = mux_addr;
            tnew_d[0] = tnew_in;
        end

        if (stall || flush) begin
            addr_d[1] = '0;
            tnew_d[1] = '0;
        end else begin
            addr_d[1] = addr_q[0];
            tnew_d[1] = dec_sat(tnew_q[0]);
        end

        for (int k = 2; k < DEPTH; k++) begin
            addr_d[k] = addr_q[k-1];
            tnew_d[k] = dec_sat(tnew_q[k-1]);
        end
    end

    // Stage registers. These clear immediately when reset goes low, discarding any in-flight addresses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                tnew_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= addr_d[k];
                tnew_q[k] <= tnew_d[k];
            end
        end
    end

    // Flatten the stage registers onto the packed output buses.
    always_comb begin
        stage_addr = '0;
        stage_tnew = '0;
        for (int k = 0; k < DEPTH; k++) begin
            stage_addr[k*WIDTH +: WIDTH] = addr_q[k];
            stage_tnew[k*TW +: TW]       = tnew_q[k];
        end
    end

`ifdef DST_HAZARD_DETECT_EN
    logic hit_found;

    // Hazard check. Any matching stage that is still too young requests a stall.
    // Only the youngest match may forward, and only once its Tnew has reached 0.
    always_comb begin
        fwd_hit   = '0;
        stall_req = 1'b0;
        hit_found = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((qry_addr != '0) && (addr_q[k] == qry_addr)) begin
                if (tnew_q[k] > qry_tuse) begin
                    stall_req = 1'b1;
                end
                if (!hit_found) begin
                    hit_found = 1'b1;
                    if (tnew_q[k] == '0) begin
                        fwd_hit[k] = 1'b1;
                    end
                end
            end
        end
    end
`else
    logic unused_qry;

    // Without the hazard comparators, the outputs stay quiet and the query is not used.
    assign unused_qry = ^{qry_addr, qry_tuse};
    assign fwd_hit    = '0;
    assign stall_req  = 1'b0;
`endif

endmodule

// File: tb/tb_dst_addr_pipe.sv
// Bench for dst_addr_pipe.
// It runs a table of pipeline vectors, then hand-built hazard, reset and select sequences.
// It finishes with random traffic compared against a behavioural model.
module tb_dst_addr_pipe;

    localparam int WIDTH = 5;
    localparam int NUM_IN = 4;
    localparam int SEL_W = 2;
    localparam int DEPTH = 3;
    localparam int TW = 2;
`ifdef DST_HAZARD_DETECT_EN
    localparam bit HAZ_ON = 1'b1;
`else
    localparam bit HAZ_ON = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_IN*WIDTH-1:0] in_addr;
    logic [SEL_W-1:0]        sel;
    logic                    wr_en;
    logic [TW-1:0]           tnew_in;
    logic                    stall;
    logic                    flush;
    logic [DEPTH*WIDTH-1:0]  stage_addr;
    logic [DEPTH*TW-1:0]     stage_tnew;
    logic [WIDTH-1:0]        qry_addr;
    logic [TW-1:0]           qry_tuse;
    logic [DEPTH-1:0]        fwd_hit;
    logic                    stall_req;

    logic [DEPTH*WIDTH-1:0]  stage_addr3;
    logic [DEPTH*TW-1:0]     stage_tnew3;
    logic [DEPTH-1:0]        fwd_hit3;
    logic                    stall_req3;

    int checks = 0;
    int errors = 0;
    int ma [DEPTH];
    int mt [DEPTH];

    typedef struct {
        logic [1:0] sel;
        logic       wr;
        logic [1:0] tn;
        logic       st;
        logic       fl;
        int         a0, a1, a2;
        int         t0, t1, t2;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    dst_addr_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .DEPTH(DEPTH), .TW(TW)) dut (
        .clk(clk), .reset(reset), .in_addr(in_addr), .sel(sel), .wr_en(wr_en),
        .tnew_in(tnew_in), .stall(stall), .flush(flush), .stage_addr(stage_addr),
        .stage_tnew(stage_tnew), .qry_addr(qry_addr), .qry_tuse(qry_tuse),
        .fwd_hit(fwd_hit), .stall_req(stall_req)
    );

    dst_addr_pipe #(.WIDTH(WIDTH), .NUM_IN(3), .SEL_W(SEL_W), .DEPTH(DEPTH), .TW(TW)) dut3 (
        .clk(clk), .reset(reset), .in_addr(in_addr[3*WIDTH-1:0]), .sel(sel), .wr_en(wr_en),
        .tnew_in(tnew_in), .stall(stall), .flush(flush), .stage_addr(stage_addr3),
        .stage_tnew(stage_tnew3), .qry_addr(qry_addr), .qry_tuse(qry_tuse),
        .fwd_hit(fwd_hit3), .stall_req(stall_req3)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] s, input logic w, input logic [1:0] t,
                                 input logic st, input logic fl);
        sel = s;
        wr_en = w;
        tnew_in = t;
        stall = st;
        flush = fl;
    endtask

    // Advance one clock. The model's next state is computed from the rules before the edge.
    task automatic step();
        int na [DEPTH];
        int nt [DEPTH];
        int s;
        for (int k = 2; k < DEPTH; k++) begin
            na[k] = ma[k-1];
            nt[k] = (mt[k-1] > 0) ? mt[k-1] - 1 : 0;
        end
        if (stall || flush) begin
            na[1] = 0;
            nt[1] = 0;
        end else begin
            na[1] = ma[0];
            nt[1] = (mt[0] > 0) ? mt[0] - 1 : 0;
        end
        s = int'(sel);
        if (flush) begin
            na[0] = 0;
            nt[0] = 0;
        end else if (stall) begin
            na[0] = ma[0];
            nt[0] = mt[0];
        end else begin
            na[0] = (wr_en && s < NUM_IN) ? int'(in_addr[s*WIDTH +: WIDTH]) : 0;
            nt[0] = int'(tnew_in);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            ma[k] = na[k];
            mt[k] = nt[k];
        end
    endtask

    task automatic checkPipe(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            checkOutput($sformatf("%s addr%0d", tag, k), 32'(stage_addr[k*WIDTH +: WIDTH]), 32'(ma[k]));
            checkOutput($sformatf("%s tnew%0d", tag, k), 32'(stage_tnew[k*TW +: TW]), 32'(mt[k]));
        end
    endtask

    // Reference hazard rules: the youngest match decides forwarding, and any too-young match requests a stall.
    task automatic checkHazard(input string tag);
        int youngest;
        int exp_fwd;
        int exp_stall;
        youngest = -1;
        exp_stall = 0;
        exp_fwd = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (qry_addr != 0 && ma[k] == int'(qry_addr)) begin
                if (mt[k] > int'(qry_tuse)) exp_stall = 1;
                if (youngest < 0) youngest = k;
            end
        end
        if (youngest >= 0 && mt[youngest] == 0) exp_fwd = 1 << youngest;
        if (!HAZ_ON) begin
            exp_fwd = 0;
            exp_stall = 0;
        end
        checkOutput({tag, " fwd_hit"}, 32'(fwd_hit), 32'(exp_fwd));
        checkOutput({tag, " stall_req"}, 32'(stall_req), 32'(exp_stall));
    endtask

    initial begin
        tbl[0]  = '{2'd1, 1'b1, 2'd2, 1'b0, 1'b0, 11, 0, 0, 2, 0, 0};
        tbl[1]  = '{2'd1, 1'b1, 2'd2, 1'b0, 1'b0, 11, 11, 0, 2, 1, 0};
        tbl[2]  = '{2'd1, 1'b1, 2'd2, 1'b0, 1'b0, 11, 11, 11, 2, 1, 0};
        tbl[3]  = '{2'd1, 1'b1, 2'd2, 1'b1, 1'b0, 11, 0, 11, 2, 0, 0};
        tbl[4]  = '{2'd1, 1'b1, 2'd2, 1'b1, 1'b0, 11, 0, 0, 2, 0, 0};
        tbl[5]  = '{2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 8, 11, 0, 1, 1, 0};
        tbl[6]  = '{2'd3, 1'b1, 2'd3, 1'b0, 1'b0, 31, 8, 11, 3, 0, 0};
        tbl[7]  = '{2'd3, 1'b1, 2'd3, 1'b1, 1'b1, 0, 0, 8, 0, 0, 0};
        tbl[8]  = '{2'd3, 1'b1, 2'd0, 1'b0, 1'b0, 31, 0, 0, 0, 0, 0};
        tbl[9]  = '{2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 0, 31, 0, 0, 0, 0};
        tbl[10] = '{2'd1, 1'b1, 2'd1, 1'b0, 1'b0, 11, 0, 31, 1, 0, 0};
        tbl[11] = '{2'd1, 1'b1, 2'd1, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0};

        reset = 1'b0;
        in_addr = {5'd31, 5'd0, 5'd11, 5'd8};
        qry_addr = '0;
        qry_tuse = '0;
        applyStimulus(2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            ma[k] = 0;
            mt[k] = 0;
        end
        repeat (2) @(posedge clk);
        #3;
        checkPipe("reset");
        checkHazard("reset");
        #2 reset = 1'b1;

        // Table of pipeline vectors, starting from the reset state.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i].sel, tbl[i].wr, tbl[i].tn, tbl[i].st, tbl[i].fl);
            step();
            checkOutput($sformatf("row%0d a0", i), 32'(stage_addr[4:0]), 32'(tbl[i].a0));
            checkOutput($sformatf("row%0d a1", i), 32'(stage_addr[9:5]), 32'(tbl[i].a1));
            checkOutput($sformatf("row%0d a2", i), 32'(stage_addr[14:10]), 32'(tbl[i].a2));
            checkOutput($sformatf("row%0d t0", i), 32'(stage_tnew[1:0]), 32'(tbl[i].t0));
            checkOutput($sformatf("row%0d t1", i), 32'(stage_tnew[3:2]), 32'(tbl[i].t1));
            checkOutput($sformatf("row%0d t2", i), 32'(stage_tnew[5:4]), 32'(tbl[i].t2));
        end

        // Stage 0 busy with address 5: it is still too young for a Tuse of 1, but not for a Tuse of 2.
        in_addr = {5'd31, 5'd0, 5'd11, 5'd5};
        applyStimulus(2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        step();
        checkPipe("busy");
        qry_addr = 5'd5;
        qry_tuse = 2'd1;
        #1;
        checkOutput("busy stall_req", 32'(stall_req), HAZ_ON ? 32'd1 : 32'd0);
        checkOutput("busy fwd_hit", 32'(fwd_hit), 32'd0);
        qry_tuse = 2'd2;
        #1;
        checkOutput("busy tuse2 stall_req", 32'(stall_req), 32'd0);

        // Stages 1 and 2 both hold address 5 as ready. The younger one, stage 1, must forward.
        applyStimulus(2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        step();
        step();
        applyStimulus(2'd1, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        checkPipe("fwd");
        qry_addr = 5'd5;
        qry_tuse = 2'd0;
        #1;
        checkOutput("fwd fwd_hit", 32'(fwd_hit), HAZ_ON ? 32'd2 : 32'd0);
        checkOutput("fwd stall_req", 32'(stall_req), 32'd0);
        qry_addr = 5'd11;
        #1;
        checkOutput("fwd s0 fwd_hit", 32'(fwd_hit), HAZ_ON ? 32'd1 : 32'd0);

        // A flush leaves address 5 only in stage 2. A query of 0 must never match.
        applyStimulus(2'd1, 1'b1, 2'd0, 1'b0, 1'b1);
        step();
        checkPipe("flush");
        qry_addr = 5'd0;
        #1;
        checkOutput("zero fwd_hit", 32'(fwd_hit), 32'd0);
        checkOutput("zero stall_req", 32'(stall_req), 32'd0);
        qry_addr = 5'd5;
        #1;
        checkOutput("old fwd_hit", 32'(fwd_hit), HAZ_ON ? 32'd4 : 32'd0);

        // Reset asserted mid-cycle with every stage busy must clear the stages before the next edge.
        applyStimulus(2'd1, 1'b1, 2'd2, 1'b0, 1'b0);
        repeat (3) step();
        checkPipe("full");
        qry_addr = 5'd11;
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            ma[k] = 0;
            mt[k] = 0;
        end
        checkOutput("async addr", 32'(stage_addr), 32'd0);
        checkOutput("async tnew", 32'(stage_tnew), 32'd0);
        checkHazard("async");
        #2 reset = 1'b1;

        // A narrower instance with three candidates: sel=2 is in range and sel=3 is out of range.
        in_addr = {5'd31, 5'd11, 5'd0, 5'd8};
        applyStimulus(2'd2, 1'b1, 2'd1, 1'b0, 1'b0);
        step();
        checkOutput("n3 sel2", 32'(stage_addr3[4:0]), 32'd11);
        applyStimulus(2'd3, 1'b1, 2'd1, 1'b0, 1'b0);
        step();
        checkOutput("n3 sel3", 32'(stage_addr3[4:0]), 32'd0);
        checkPipe("n4 sel3");

        // Random traffic with a small address space, so that queries often hit.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_IN; i++) in_addr[i*WIDTH +: WIDTH] = 5'($urandom_range(0, 7));
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
            qry_addr = 5'($urandom_range(0, 7));
            qry_tuse = 2'($urandom_range(0, 3));
            #1;
            checkHazard($sformatf("rnd%0d", n));
            step();
            checkPipe($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dst_addr_pipe.md
Name: dst_addr_pipe

Overview:
- Parametrised successor to the 2:1 destination-register-address mux.
- Selects the write-register address of the instruction in D from NUM_IN candidates (e.g. rt, rd, 31), then carries it with its Tnew down a DEPTH-stage pipeline (E/M/W).
- Supports stall and flush.
- Compares a source-register query against all in-flight stages to produce forwarding-hit and stall-request signals for the hazard unit.

Parameters:
- WIDTH, 5, register-address width.
- NUM_IN, 4, number of candidate addresses; ≥2.
- SEL_W, 2, select width; ≥ clog2(NUM_IN).
- DEPTH, 3, number of pipeline stages after selection; ≥2.
- TW, 2, Tnew/Tuse counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_addr  in  NUM_IN*WIDTH  candidate addresses; candidate i at [i*WIDTH +: WIDTH].
- sel  in  SEL_W  candidate index.
- wr_en  in  1  D-stage instruction writes a register.
- tnew_in  in  TW  Tnew of the D-stage instruction, as seen at stage 0.
- stall  in  1  hold stage 0 and insert a bubble into stage 1.
- flush  in  1  load a bubble into stage 0.
- stage_addr  out  DEPTH*WIDTH  registered address per stage; stage k at [k*WIDTH +: WIDTH].
- stage_tnew  out  DEPTH*TW  registered Tnew per stage.
- qry_addr  in  WIDTH  source register being read in D.
- qry_tuse  in  TW  Tuse of that read.
- fwd_hit  out  DEPTH  one-hot: youngest stage holding qry_addr with Tnew==0.
- stall_req  out  1  a pending result is not ready in time.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage_addr = 0 and all stage_tnew = 0.
  - fwd_hit and stall_req evaluate to 0, because every stage holds address 0.
  - Release of reset takes effect at the next clk edge.
- Bubble definition: addr=0, tnew=0. Address 0 means "no write" and never matches a query.
- Selection (combinational into stage 0):
  - mux_addr = in_addr[sel] if wr_en=1 and sel<NUM_IN.
  - mux_addr = 0 if wr_en=0 or sel≥NUM_IN (out-of-range select).
- Stage 0 update on each rising edge:
  - flush=1: loads a bubble. Flush wins over stall.
  - Else stall=1: holds its current value.
  - Else: loads {mux_addr, tnew_in}.
- Stage 1 update:
  - stall=1 or flush=1: loads a bubble.
  - Else: loads stage 0 with tnew decremented, saturating at 0.
- Stages k≥2: always load stage k-1 with tnew decremented, saturating at 0. stall and flush never affect them.
- Latency: a captured address appears at stage_addr[0] one cycle after capture and at stage k after k+1 cycles, absent stall/flush.
- Hazard logic (combinational):
  - Stage k matches when stage_addr[k]==qry_addr and qry_addr≠0.
  - stall_req = 1 if any matching stage has tnew > qry_tuse.
  - fwd_hit = one-hot of the lowest-index matching stage with tnew==0.
  - fwd_hit is 0 if the lowest-index match has tnew≠0. Younger data always shadows older data.
  - If no stage matches, fwd_hit=0 and stall_req=0.
- Simultaneous stall and flush: stage 0 and stage 1 both become bubbles.
- Reset asserted mid-stream: all stages clear immediately, without waiting for clk. In-flight addresses are discarded.

Optional Feature:
- Macro: DST_HAZARD_DETECT_EN.
- Defined: fwd_hit and stall_req are driven as described in Behaviour.
- Undefined: the comparators are not built; fwd_hit=0 and stall_req=0 constantly.
- Undefined: qry_addr and qry_tuse are ignored; all pipeline behaviour is unchanged.

Test Plan:
- Reset, then release reset; drive in_addr={31,0,11,8} (candidates 3..0), sel=1, wr_en=1, tnew_in=2 -> after 1 clk stage_addr[0]=11, tnew 2; after 2 clks stage_addr[1]=11, tnew 1; after 3 clks stage_addr[2]=11, tnew 0.
- Same setup with stall=1 for 2 cycles -> stage 0 holds 11 both cycles; stage 1 shows bubble (0,0) both cycles; stage 2 receives the bubble one cycle later; 11 resumes advancing when stall=0.
- stall=1 and flush=1 in the same cycle while stage 0=11 -> stage 0=0 and stage 1=0 after the edge.
- Hazard, stage 0 busy: stage 0 addr=5, tnew=2; qry_addr=5, qry_tuse=1 -> stall_req=1, fwd_hit=0.
- Hazard, forwarding: stage 1 addr=5, tnew=0, stage 2 addr=5, tnew=0, stage 0 ≠5 -> fwd_hit=3'b010, stall_req=0.
- Hazard, address 0: qry_addr=0 with stage 0 addr=0 -> fwd_hit=0, stall_req=0.
- Reset pulsed low mid-cycle with all stages non-zero -> outputs go to 0 before the next clk edge.
- Select handling: wr_en=0, sel=2 -> stage 0 captures 0. With NUM_IN=3 and sel=3 -> stage 0 captures 0.
- Macro off: the forwarding-hit stimulus above -> fwd_hit=0, stall_req=0.
